// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: double-dabble, one bit per clock, with a
// start/busy/done handshake, sign flag and leading-zero blanking mask.
module bin2bcd_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic [DIGITS-1:0]     blank
);
    localparam int BCDW = 4 * DIGITS;
    localparam int CNTW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic              signed_q, signed_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BCDW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              neg_next_q, neg_next_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BCDW-1:0]   bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [DIGITS-1:0] blank_q, blank_d;

    logic [BCDW-1:0]   adj_acc;
    logic [BCDW-1:0]   shift_acc;
    logic [DIGITS-1:0] final_blank;
    logic [WIDTH-1:0]  neg_mag;

    always_comb begin
        adj_acc = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) adj_acc[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            else                         adj_acc[4*i +: 4] = acc_q[4*i +: 4];
        end
        shift_acc = {adj_acc[BCDW-2:0], mag_q[WIDTH-1]};
        // A digit is blanked when it and every digit above it are zero; digit 0 never is.
        final_blank = '0;
        for (int i = 1; i < DIGITS; i++) final_blank[i] = ((shift_acc >> (4*i)) == '0);
        // The most negative input negates to itself, which read unsigned is the right magnitude.
        neg_mag = ~bin_q + WIDTH'(1);
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        signed_d   = signed_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_next_d = neg_next_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        neg_d      = neg_q;
        blank_d    = blank_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    bin_d    = bin_in;
                    signed_d = signed_mode;
                    busy_d   = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (signed_q && bin_q[WIDTH-1]) begin
                    mag_d      = neg_mag;
                    neg_next_d = 1'b1;
                end else begin
                    mag_d      = bin_q;
                    neg_next_d = 1'b0;
                end
                acc_d   = '0;
                cnt_d   = CNTW'(WIDTH);
                state_d = SHIFT;
            end
            SHIFT: begin
                acc_d = shift_acc;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = shift_acc;
                    neg_d   = neg_next_q;
                    blank_d = final_blank;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            signed_q   <= 1'b0;
            mag_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_next_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            neg_q      <= 1'b0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            signed_q   <= signed_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_next_q <= neg_next_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            neg_q      <= neg_d;
            blank_q    <= blank_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign neg     = neg_q;
    assign blank   = blank_q;
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Self-checking bench for bin2bcd_seq_ctrl: directed corner cases, handshake
// rules and randomized conversions against a decimal arithmetic model.
module tb_bin2bcd_seq_ctrl;
    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        signed_mode = 1'b0;
    logic        busy, done, neg;
    logic [19:0] bcd_out;
    logic [4:0]  blank;

    int compared = 0;
    int mismatched = 0;

    logic [19:0] hold_bcd;
    logic        hold_neg;
    logic [4:0]  hold_blank;

    always #5 clk = ~clk;

    bin2bcd_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bin_in      (bin_in),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .neg         (neg),
        .blank       (blank)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int magOf(input logic [15:0] v, input logic sm);
        return (sm && v[15]) ? 65536 - int'(v) : int'(v);
    endfunction

    function automatic logic [19:0] modelBcd(input int m);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] modelBlank(input int m);
        logic [4:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            r[i] = (m < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic checkResult(input string tag, input logic [15:0] v, input logic sm);
        int m;
        m = magOf(v, sm);
        checkOutput({tag, ".bcd"}, 32'(bcd_out), 32'(modelBcd(m)));
        checkOutput({tag, ".neg"}, 32'(neg), 32'(sm && v[15]));
        checkOutput({tag, ".blank"}, 32'(blank), 32'(modelBlank(m)));
        hold_bcd   = modelBcd(m);
        hold_neg   = sm && v[15];
        hold_blank = modelBlank(m);
    endtask

    // Runs one full conversion; inputs are scrambled right after capture.
    task automatic applyStimulus(input string tag, input logic [15:0] v, input logic sm);
        int cyc;
        @(negedge clk);
        bin_in = v;
        signed_mode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin_in = 16'($urandom);
        signed_mode = 1'($urandom);
        cyc = 1;
        checkOutput({tag, ".busy_load"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 6 && done !== 1'b1) begin
                checkOutput({tag, ".hold_bcd"}, 32'(bcd_out), 32'(hold_bcd));
                checkOutput({tag, ".hold_neg"}, 32'(neg), 32'(hold_neg));
                checkOutput({tag, ".hold_blank"}, 32'(blank), 32'(hold_blank));
            end
        end
        checkOutput({tag, ".latency"}, 32'(cyc), 32'd18);
        if (done === 1'b1) begin
            checkResult(tag, v, sm);
            checkOutput({tag, ".busy_done"}, 32'(busy), 32'd0);
        end
        @(negedge clk);
        checkOutput({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int done_seen;
        int busy_seen;
        int last_done;
        int n_done;
        logic [15:0] rv;
        logic        rs;

        hold_bcd = '0;
        hold_neg = 1'b0;
        hold_blank = '0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.bcd", 32'(bcd_out), 32'd0);
        checkOutput("rst.neg", 32'(neg), 32'd0);
        checkOutput("rst.blank", 32'(blank), 32'd0);

        applyStimulus("umax", 16'hFFFF, 1'b0);
        checkOutput("umax.literal", 32'(bcd_out), 32'h65535);
        applyStimulus("smin", 16'h8000, 1'b1);
        applyStimulus("sneg7", 16'hFFF9, 1'b1);
        applyStimulus("zero", 16'h0000, 1'b0);
        applyStimulus("hundred", 16'd100, 1'b0);
        applyStimulus("u8000", 16'h8000, 1'b0);
        applyStimulus("sneg1", 16'hFFFF, 1'b1);
        applyStimulus("spos", 16'h7FFF, 1'b1);

        // A start pulse during SHIFT must neither disturb nor queue a conversion.
        @(negedge clk);
        bin_in = 16'd100;
        signed_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        bin_in = 16'd42;
        signed_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("ignore.latency", 32'(cyc), 32'd18);
        checkResult("ignore", 16'd100, 1'b0);

        // Start raised only during FINISH must be dropped.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_seen = 0;
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        checkOutput("finish_start.done", 32'(done_seen), 32'd0);
        checkOutput("finish_start.busy", 32'(busy_seen), 32'd0);
        checkOutput("finish_start.hold", 32'(bcd_out), 32'h00100);

        // Start held high gives back-to-back conversions.
        @(negedge clk);
        bin_in = 16'd9999;
        signed_mode = 1'b0;
        start = 1'b1;
        last_done = -1;
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                checkOutput("held.bcd", 32'(bcd_out), 32'h09999);
                if (last_done >= 0) checkOutput("held.spacing", 32'(i - last_done), 32'd19);
                last_done = i;
                n_done++;
            end
        end
        start = 1'b0;
        checkOutput("held.count", 32'(n_done), 32'd3);
        repeat (25) @(negedge clk);
        checkResult("held.final", 16'd9999, 1'b0);

        // Asynchronous reset during SHIFT cycle 5 aborts the conversion.
        @(negedge clk);
        bin_in = 16'hFFFF;
        signed_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        checkOutput("midrst.done", 32'(done), 32'd0);
        checkOutput("midrst.bcd", 32'(bcd_out), 32'd0);
        checkOutput("midrst.neg", 32'(neg), 32'd0);
        checkOutput("midrst.blank", 32'(blank), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        checkOutput("midrst.no_done", 32'(done_seen), 32'd0);
        checkOutput("midrst.idle", 32'(busy_seen), 32'd0);
        hold_bcd = '0;
        hold_neg = 1'b0;
        hold_blank = '0;

        for (int n = 0; n < 200; n++) begin
            rv = 16'($urandom);
            if (n % 8 == 0) rv = 16'($urandom_range(0, 120));
            rs = 1'($urandom_range(0, 1));
            applyStimulus("rand", rv, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
